// File: rtl/branch_pkg.sv
// Shared branch-condition encodings and BHT counter helpers.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_e;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic bht_state_e bht_next(input bht_state_e state, input logic taken);
    bht_state_e nxt;
    nxt = state;
    case (state)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// IF lookup and EX resolve signals between the pipeline and the branch unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            branch;
  logic [2:0]      funct3;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ex_pred_taken;
  logic            taken;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            illegal_funct3;

  modport master (
    output if_pc, ex_valid, branch, funct3, ex_pc, imm, rs1_data, rs2_data, ex_pred_taken,
    input  if_pred_taken, taken, redirect_valid, redirect_pc, flush, illegal_funct3
  );

  modport slave (
    input  if_pc, ex_valid, branch, funct3, ex_pc, imm, rs1_data, rs2_data, ex_pred_taken,
    output if_pred_taken, taken, redirect_valid, redirect_pc, flush, illegal_funct3
  );
endinterface

// File: rtl/branch_bht.sv
// Branch history table: 2-bit saturating counters, async read, sync update.
module branch_bht
  import branch_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_e       rd_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_state_e mem [DEPTH];

  // Read returns the stored value, so a same-cycle update is not visible yet.
  assign rd_state = mem[rd_idx];

  // All entries start weakly not-taken; accepted branches train their entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= WNT;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= bht_next(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves RV64 conditional branches in EX, trains the BHT, and on a
// mispredict issues a redirect pulse plus a stretched flush.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned BHT_DEPTH    = 16,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PREDICT_EN   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  branch_resolve_unit_if.slave bus,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned FC_W  = $clog2(FLUSH_CYCLES + 1);

  logic            cond_c;
  logic            illegal_c;
  logic            accept_c;
  logic            mis_c;
  logic [XLEN-1:0] target_c;
  logic [FC_W-1:0] flush_cnt;
  logic            unused_if_pc;

  // Branch condition decode; reserved encodings resolve not-taken.
  always_comb begin
    cond_c    = 1'b0;
    illegal_c = 1'b0;
    case (bus.funct3)
      F3_BEQ:  cond_c = (bus.rs1_data == bus.rs2_data);
      F3_BNE:  cond_c = (bus.rs1_data != bus.rs2_data);
      F3_BLT:  cond_c = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
      F3_BGE:  cond_c = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
      F3_BLTU: cond_c = (bus.rs1_data <  bus.rs2_data);
      F3_BGEU: cond_c = (bus.rs1_data >= bus.rs2_data);
      default: illegal_c = 1'b1;
    endcase
  end

  // Wrong-path instructions (under flush) and stalled cycles are never accepted.
  assign accept_c = bus.ex_valid & bus.branch & ~bus.flush & ~stall;
  assign mis_c    = accept_c & (cond_c != bus.ex_pred_taken);
  assign target_c = cond_c ? (bus.ex_pc + bus.imm) : (bus.ex_pc + XLEN'(4));

  // Registered resolve results; taken and redirect_pc hold between branches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.taken          <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.illegal_funct3 <= 1'b0;
    end else if (!stall) begin
      bus.redirect_valid <= mis_c;
      bus.illegal_funct3 <= accept_c & illegal_c;
      if (accept_c) begin
        bus.taken       <= cond_c;
        bus.redirect_pc <= target_c;
      end
    end
  end

  // Flush stretcher: loaded on mispredict, counts down on unstalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
      bus.flush <= 1'b0;
    end else if (!stall) begin
      if (mis_c) begin
        flush_cnt <= FC_W'(FLUSH_CYCLES);
        bus.flush <= 1'b1;
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FC_W'(1);
        bus.flush <= (flush_cnt != FC_W'(1));
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (accept_c && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mis_c && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  assign unused_if_pc = ^bus.if_pc;

  if (PREDICT_EN != 0) begin : gen_bht
    bht_state_e rd_state;

    branch_bht #(
      .DEPTH (BHT_DEPTH)
    ) u_bht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (bus.if_pc[IDX_W+1:2]),
      .rd_state (rd_state),
      .wr_en    (accept_c),
      .wr_idx   (bus.ex_pc[IDX_W+1:2]),
      .wr_taken (cond_c)
    );

    assign bus.if_pred_taken = rd_state[1];
  end else begin : gen_static
    assign bus.if_pred_taken = 1'b0;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Resolves all six RV64 conditional branches in EX and registers the result.
- Keeps a 2-bit saturating branch history table (BHT) that IF consults for prediction.
- On a mispredict, issues a one-cycle redirect and a stretched multi-cycle flush; also keeps branch and mispredict statistics.

Parameters:
- XLEN, 64: datapath and PC width.
- BHT_DEPTH, 16: BHT entries; power of two, at least 2. IDX_W = log2(BHT_DEPTH).
- FLUSH_CYCLES, 2: number of cycles flush stays high per mispredict; at least 1.
- CNT_W, 32: width of the statistics counters.
- PREDICT_EN, 1: 1 = BHT prediction; 0 = static not-taken (BHT forced off).

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Asynchronous, active-low reset.
- stall  in  1  Pipeline hold; freezes all state.
- if_pc  in  XLEN  PC being fetched, used for lookup.
- if_pred_taken  out  1  Combinational prediction for if_pc.
- ex_valid  in  1  EX holds a valid instruction.
- branch  in  1  EX instruction is a conditional branch.
- funct3  in  3  Branch condition.
- ex_pc  in  XLEN  PC of the EX instruction.
- imm  in  XLEN  Sign-extended branch offset.
- rs1_data  in  XLEN  Operand 1.
- rs2_data  in  XLEN  Operand 2.
- ex_pred_taken  in  1  Prediction made in IF, carried down the pipe with the instruction.
- taken  out  1  Registered resolved direction.
- redirect_valid  out  1  One-cycle pulse on a mispredict.
- redirect_pc  out  XLEN  Correct next PC; valid while redirect_valid is high.
- flush  out  1  Squashes IF/ID/EX.
- illegal_funct3  out  1  Registered; funct3 was 010 or 011.
- branch_count  out  CNT_W  Number of resolved branches.
- mispredict_count  out  CNT_W  Number of mispredicts.

Behaviour:
- Reset values: taken, redirect_valid, flush, illegal_funct3 = 0; redirect_pc, both counters and the flush counter = 0; every BHT entry = 2'b01 (weakly not-taken). Reset is asynchronous and may arrive mid-flush; everything clears immediately.
- Accept condition: accept = ex_valid & branch & !flush & !stall. An instruction in EX while flush is high is wrong-path and is ignored, including for the BHT and counters.
- Condition by funct3:
  - 000 eq, 001 ne
  - 100 signed <, 101 signed >=
  - 110 unsigned <, 111 unsigned >=
  - 010, 011: not-taken, and illegal_funct3 is set for one cycle.
- Latency: the compare is combinational; taken, redirect_valid, redirect_pc and illegal_funct3 are registered on the edge that ends the accept cycle.
- Without an accept, taken holds its last value; redirect_valid and illegal_funct3 go to 0.
- Mispredict: mis = accept & (cond != ex_pred_taken).
- Redirect target: cond ? ex_pc + imm : ex_pc + 4, truncated to XLEN (wraps modulo 2^XLEN).
- Flush:
  - A mispredict loads the flush counter with FLUSH_CYCLES; flush = (counter != 0), decrementing once per non-stalled cycle.
  - flush rises in the same cycle as redirect_valid.
  - A mispredict cannot be accepted while flush is high, so no restart case exists.
- Stall: while stall is high, every register (BHT, counters, flush counter, outputs) holds its value.
- BHT index: ex_pc[IDX_W+1:2], and likewise if_pc[IDX_W+1:2] for lookup.
- BHT update on accept: increment toward 11 when cond=1, decrement toward 00 when cond=0; saturating at both ends.
- if_pred_taken = entry[1] when PREDICT_EN=1, otherwise 0.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value.
- With PREDICT_EN=0, the BHT neither reads nor writes, so every taken branch mispredicts.
- Counters: branch_count increments on accept; mispredict_count increments on mis. Both saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Shared package branch_pkg:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - 2-bit counter encodings: SNT = 00, WNT = 01, WT = 10, ST = 11.
  - Function bht_next(state, taken) implementing the saturating update.
- Sub-module branch_bht: storage array, combinational read port, synchronous saturating write port, and reset of all entries.

Test Plan:
- Reset, then beq with rs1 = rs2 = 5, ex_pc = 0x100, imm = 0x20, ex_pred_taken = 0 -> next cycle taken = 1, redirect_valid = 1, redirect_pc = 0x120; flush high for exactly 2 cycles; mispredict_count = 1.
- Signed vs unsigned with rs1 = 0xFFFF_FFFF_FFFF_FFFF, rs2 = 1 -> blt taken, bltu not-taken, bge not-taken, bgeu taken; with pred = actual, redirect_valid stays 0.
- Three taken beq at ex_pc = 0x40 -> BHT entry 0 goes 01 -> 10 -> 11 -> 11; if_pred_taken for if_pc = 0x40 reads 1 after the first update; an if_pc = 0x40 lookup in the same cycle as the first update reads 0.
- Mispredict followed by a valid mispredicting branch in the next two cycles -> that branch is ignored (no count, no BHT change, no redirect); an identical branch after flush falls is accepted.
- funct3 = 010 with branch = 1 -> illegal_funct3 pulses, taken = 0; stall held 3 cycles mid-flush -> flush length extends by 3; reset asserted mid-flush -> flush = 0 immediately.
- With PREDICT_EN = 0 and CNT_W = 2: four taken branches -> mispredict_count saturates at 3; if_pred_taken stays 0.
